// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matrix_pkg
// Desc     : Shared constants and types for the LED-matrix serial link.
//            The matrix transmitter uses the same definitions, so keep it
//            stable.
// Revision : 1.0 - initial release
// ============================================================================
package matrix_pkg;

    localparam int MATRIX_DIM  = 16;
    localparam int LINK_WORD_W = 32;
    localparam int SUBFRAMES   = 4;
    localparam int COL_W       = $clog2(MATRIX_DIM);
    localparam int VISIT_W     = $clog2(SUBFRAMES);

    typedef logic [1:0]             pix_t;
    typedef pix_t [MATRIX_DIM-1:0]  pix_col_t;
    typedef logic [VISIT_W-1:0]     visit_t;

    typedef struct packed {
        logic             valid;
        logic [COL_W-1:0] col;
    } col_dec_t;

    // The cathode field is active-low. Bit p of the field drives column
    // MATRIX_DIM-1-p. The word is usable only when exactly one column is
    // driven.
    function automatic col_dec_t decode_cathode(input logic [MATRIX_DIM-1:0] cath);
        col_dec_t d;
        int       zeros;
        d     = '0;
        zeros = 0;
        for (int p = 0; p < MATRIX_DIM; p++) begin
            if (!cath[p]) begin
                zeros++;
                d.col = COL_W'(MATRIX_DIM - 1 - p);
            end
        end
        d.valid = (zeros == 1);
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_serial_rx_sync.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge
// Desc     : Multi-flop synchronizer for one asynchronous input. It also
//            produces single-cycle rise and fall pulses, which are detected
//            on the synchronized copy. SYNC_STAGES must be at least 2.
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Synchronizer chain plus a one-cycle history flop for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];
    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule
`default_nettype wire

// File: rtl/matrix_serial_rx.sv
`default_nettype none
// ============================================================================
// Module   : matrix_serial_rx
// Desc     : Receives the LED-matrix link, which is a shift-register style
//            link with serial_clk, serial_data, rclk and clear. Each latched
//            word is decoded into a single column. For each column, four
//            column visits are accumulated into 2-bit intensities and then
//            published to a framebuffer. The framebuffer can be read
//            through rd_col and rd_row.
// Config   : MATRIX_RX_ERR_CNT_EN - adds the err_cnt port, which counts
//            discarded words and saturates at 255.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_serial_rx
    import matrix_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       serial_clk,
    input  logic       serial_data,
    input  logic       rclk,
    input  logic       clear,
    input  logic [3:0] rd_col,
    input  logic [3:0] rd_row,
    output logic [1:0] rd_pix,
    output logic       word_valid,
    output logic       frame_done
`ifdef MATRIX_RX_ERR_CNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    localparam int c_SCLK = 0;
    localparam int c_DATA = 1;
    localparam int c_RCLK = 2;
    localparam int c_CLR  = 3;

    logic [3:0]             w_async;
    logic [3:0]             w_sync;
    logic [3:0]             w_rise;
    logic [3:0]             w_fall;
    logic                   w_unused_edges;

    logic [LINK_WORD_W-1:0] r_shreg;
    logic [LINK_WORD_W-1:0] r_word;
    logic                   r_word_new;
    logic                   r_rclk_prev;
    logic [LINK_WORD_W-1:0] w_shift_next;

    col_dec_t               w_dec;
    logic [MATRIX_DIM-1:0]  w_anode;
    pix_col_t               w_acc_next;

    pix_col_t               r_acc   [MATRIX_DIM];
    pix_col_t               r_fb    [MATRIX_DIM];
    visit_t                 r_visit [MATRIX_DIM];
    pix_t                   r_rd_pix;
    logic                   r_word_valid;
    logic                   r_frame_done;

    assign w_async = {clear, rclk, serial_data, serial_clk};

    for (genvar g = 0; g < 4; g++) begin : g_sync
        sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_async (w_async[g]),
            .o_sync  (w_sync[g]),
            .o_rise  (w_rise[g]),
            .o_fall  (w_fall[g])
        );
    end

    // Only the serial_clk fall and the levels of data, rclk and clear are
    // used. The remaining edge pulses are tied off here.
    assign w_unused_edges = ^{w_rise, w_fall[c_CLR:c_DATA], w_sync[c_SCLK]};

    // An active-low clear forces the shift register to zero. It also
    // overrides a shift that happens in the same cycle.
    assign w_shift_next = w_sync[c_CLR] ? {r_shreg[LINK_WORD_W-2:0], w_sync[c_DATA]}
                                        : '0;

    // Shift on serial_clk falls. When rclk rises, latch the post-shift
    // contents into the word register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shreg     <= '0;
            r_word      <= '0;
            r_word_new  <= 1'b0;
            r_rclk_prev <= 1'b0;
        end else begin
            r_word_new <= 1'b0;
            if (!w_sync[c_CLR] || w_fall[c_SCLK]) begin
                r_shreg <= w_shift_next;
            end
            if (w_fall[c_SCLK]) begin
                r_rclk_prev <= w_sync[c_RCLK];
                if (w_sync[c_RCLK] && !r_rclk_prev) begin
                    r_word     <= w_shift_next;
                    r_word_new <= 1'b1;
                end
            end
        end
    end

    assign w_dec   = decode_cathode(r_word[LINK_WORD_W-1 -: MATRIX_DIM]);
    assign w_anode = r_word[MATRIX_DIM-1:0];

    // Saturating per-row increment of the addressed column. Anode bit
    // MATRIX_DIM-1-j drives row j.
    always_comb begin
        w_acc_next = r_acc[w_dec.col];
        for (int j = 0; j < MATRIX_DIM; j++) begin
            if (w_anode[MATRIX_DIM-1-j] && (w_acc_next[j] != 2'd3)) begin
                w_acc_next[j] = w_acc_next[j] + 2'd1;
            end
        end
    end

    // Accumulate valid words, publish a column on its last visit, and
    // register the framebuffer read port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < MATRIX_DIM; i++) begin
                r_acc[i]   <= '0;
                r_fb[i]    <= '0;
                r_visit[i] <= '0;
            end
            r_rd_pix     <= '0;
            r_word_valid <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            r_frame_done <= 1'b0;
            r_rd_pix     <= r_fb[rd_col][rd_row];
            if (r_word_new && w_dec.valid) begin
                r_word_valid          <= 1'b1;
                r_visit[w_dec.col]    <= r_visit[w_dec.col] + visit_t'(1);
                if (r_visit[w_dec.col] == visit_t'(SUBFRAMES - 1)) begin
                    r_fb[w_dec.col]  <= w_acc_next;
                    r_acc[w_dec.col] <= '0;
                    r_frame_done     <= (w_dec.col == COL_W'(MATRIX_DIM - 1));
                end else begin
                    r_acc[w_dec.col] <= w_acc_next;
                end
            end
        end
    end

`ifdef MATRIX_RX_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    // Count latched words that were rejected by the cathode check
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (r_word_new && !w_dec.valid && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

    assign rd_pix     = r_rd_pix;
    assign word_valid = r_word_valid;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_matrix_serial_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_serial_rx
// Desc     : Directed self-checking bench for matrix_serial_rx. Expected
//            words go to a queue when they are sent, and the monitor pops
//            them when word_valid appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_serial_rx;

    localparam int HALF = 5;   // clk cycles per serial_clk phase

    logic       clk = 1'b0;
    logic       rst_n;
    logic       serial_clk;
    logic       serial_data;
    logic       rclk;
    logic       clear;
    logic [3:0] rd_col;
    logic [3:0] rd_row;
    logic [1:0] rd_pix;
    logic       word_valid;
    logic       frame_done;
`ifdef MATRIX_RX_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int          checks   = 0;
    int          failures = 0;
    int          wv_cnt   = 0;
    int          fd_cnt   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    always #5 clk = ~clk;

    matrix_serial_rx #(.SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .serial_clk  (serial_clk),
        .serial_data (serial_data),
        .rclk        (rclk),
        .clear       (clear),
        .rd_col      (rd_col),
        .rd_row      (rd_row),
        .rd_pix      (rd_pix),
        .word_valid  (word_valid),
        .frame_done  (frame_done)
`ifdef MATRIX_RX_ERR_CNT_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Cathode active-low, so column c is selected by bit 31-c. Row j is
    // driven by bit 15-j.
    function automatic logic [31:0] mk_word(input int col, input logic [15:0] rows);
        logic [15:0] cath;
        logic [15:0] an;
        cath = 16'hFFFF;
        cath[15-col] = 1'b0;
        for (int j = 0; j < 16; j++) an[15-j] = rows[j];
        return {cath, an};
    endfunction

    function automatic logic [1:0] diag_pix(input int c, input int r);
        if (r == c)           return 2'd3;
        else if (r == 15 - c) return 2'd1;
        else                  return 2'd0;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input logic rk);
        serial_clk  = 1'b1;
        serial_data = b;
        rclk        = rk;
        idle(HALF);
        serial_clk  = 1'b0;
        idle(HALF);
    endtask

    // Sends bits n-1 down to 0 of w, MSB first. If rk_last is set, rclk is
    // raised with the final bit.
    task automatic send_word(input logic [31:0] w, input int n, input logic rk_last);
        for (int i = n - 1; i >= 0; i--) send_bit(w[i], rk_last && (i == 0));
        rclk = 1'b0;
    endtask

    task automatic send_exp(input logic [31:0] w);
        exp_q.push_back(w);
        send_word(w, 32, 1'b1);
    endtask

    task automatic read_pix(input int c, input int r, input logic [1:0] exp, input string tag);
        rd_col = 4'(c);
        rd_row = 4'(r);
        @(negedge clk);
        chk(tag, {30'd0, rd_pix}, {30'd0, exp});
    endtask

    // Scoreboard monitor: each accepted word must match the oldest
    // pending word that was sent.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (frame_done) fd_cnt++;
            if (word_valid) begin
                wv_cnt++;
                if (exp_q.size() == 0) begin
                    chk("wv_unexpected", {31'd0, word_valid}, 32'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("word", dut.r_word, mon_exp);
                end
            end
        end
    end

    initial begin
        int wv0;
        int fd0;
        logic [15:0] rows;

        rst_n = 1'b0; serial_clk = 1'b0; serial_data = 1'b0;
        rclk = 1'b0; clear = 1'b1; rd_col = 4'd0; rd_row = 4'd0;
        idle(4);
        chk("rst_rd_pix", {30'd0, rd_pix}, 32'd0);
        chk("rst_word_valid", {31'd0, word_valid}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        rst_n = 1'b1;
        idle(4);

        // Single column-15 word: accepted once, nothing published yet
        send_exp(32'hFFFE8001);
        idle(4);
        chk("single_wv_cnt", 32'(wv_cnt), 32'd1);
        chk("single_no_frame", 32'(fd_cnt), 32'd0);
        chk("single_pending", 32'(exp_q.size()), 32'd0);
        read_pix(15, 0, 2'd0, "single_not_published");

        // Three more visits (last one dark) complete column 15
        send_exp(32'hFFFE8001);
        send_exp(32'hFFFE8001);
        send_exp(32'hFFFE0000);
        idle(4);
        chk("col15_frame_done", 32'(fd_cnt), 32'd1);
        chk("col15_wv_cnt", 32'(wv_cnt), 32'd4);
        for (int r = 0; r < 16; r++)
            read_pix(15, r, (r == 0 || r == 15) ? 2'd3 : 2'd0, "col15_pix");

        // Two cathode zeros: discarded, must not touch acc or visit
        wv0 = wv_cnt;
        send_word(32'hFFFC4000, 32, 1'b1);
        idle(4);
        chk("bad_no_wv", 32'(wv_cnt), 32'(wv0));
`ifdef MATRIX_RX_ERR_CNT_EN
        chk("bad_err_cnt", {24'd0, err_cnt}, 32'd1);
`endif
        send_exp(32'hFFFE4000);
        send_exp(32'hFFFE0000);
        send_exp(32'hFFFE0000);
        send_exp(32'hFFFE0000);
        idle(4);
        chk("bad_frame_done", 32'(fd_cnt), 32'd2);
        read_pix(15, 1, 2'd1, "bad_acc_row1");
        read_pix(15, 0, 2'd0, "bad_acc_row0");

        // Clear mid-word: only the 31 bits sent after release may remain
        wv0 = wv_cnt;
        send_word(32'h000000FF, 8, 1'b0);
        clear = 1'b0;
        for (int p = 0; p < 4; p++) send_bit(1'b1, 1'b0);
        clear = 1'b1;
        idle(HALF);
        exp_q.push_back(32'h7FFFC003);
        send_word(32'h7FFFC003, 31, 1'b1);
        idle(4);
        chk("clear_wv", 32'(wv_cnt), 32'(wv0 + 1));
        chk("clear_pending", 32'(exp_q.size()), 32'd0);
`ifdef MATRIX_RX_ERR_CNT_EN
        chk("clear_err_cnt", {24'd0, err_cnt}, 32'd1);
`endif

        // Reset after 20 bits of a word
        read_pix(15, 1, 2'd1, "pre_rst_pix");
        send_word(32'h000FFFE8, 20, 1'b0);
        rst_n = 1'b0;
        idle(3);
        chk("mid_rst_rd_pix", {30'd0, rd_pix}, 32'd0);
        chk("mid_rst_wv", {31'd0, word_valid}, 32'd0);
        chk("mid_rst_fd", {31'd0, frame_done}, 32'd0);
`ifdef MATRIX_RX_ERR_CNT_EN
        chk("mid_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
`endif
        rst_n = 1'b1;
        idle(4);
        read_pix(15, 1, 2'd0, "post_rst_fb");
        wv0 = wv_cnt;
        send_exp(32'hFFFE8001);
        idle(4);
        chk("post_rst_wv", 32'(wv_cnt), 32'(wv0 + 1));
        chk("post_rst_pending", 32'(exp_q.size()), 32'd0);

        // Full diagonal frame, starting from a clean state
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(4);
        fd0 = fd_cnt;
        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k < 16; k++) begin
                rows = '0;
                if (v < 3)  rows[k] = 1'b1;
                if (v == 0) rows[15-k] = 1'b1;
                send_exp(mk_word(k, rows));
            end
        end
        idle(4);
        chk("diag_frame_done", 32'(fd_cnt), 32'(fd0 + 1));
        chk("diag_pending", 32'(exp_q.size()), 32'd0);
        for (int c = 0; c < 16; c++)
            for (int r = 0; r < 16; r++)
                read_pix(c, r, diag_pix(c, r), "diag_pix");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matrix_serial_rx.md
MATRIX_SERIAL_RX -- requirements
Module: matrix_serial_rx

Interface
REQ-001 The block SHALL have one parameter: SYNC_STAGES, default 2, the number of synchronizer flops on each serial input (minimum 2).
REQ-002 The block SHALL have one clock and a synchronous, active-low reset.
REQ-003 Port clk: input, 1 bit; system clock; all state changes on its rising edge.
REQ-004 Port rst_n: input, 1 bit; synchronous, active-low reset.
REQ-005 Port serial_clk: input, 1 bit; link shift clock; asynchronous to clk.
REQ-006 Port serial_data: input, 1 bit; link data bit.
REQ-007 Port rclk: input, 1 bit; link latch strobe.
REQ-008 Port clear: input, 1 bit; active-low shift-register clear.
REQ-009 Port rd_col: input, 4 bits; read column index.
REQ-010 Port rd_row: input, 4 bits; read row index.
REQ-011 Port rd_pix: output, 2 bits; published intensity of the addressed pixel.
REQ-012 Port word_valid: output, 1 bit; 1-cycle pulse when a decoded word is accepted.
REQ-013 Port frame_done: output, 1 bit; 1-cycle pulse when column 15 is published.
REQ-014 Port err_cnt: output, 8 bits; present only under the configuration macro (see Configuration).

Function
REQ-015 serial_clk, serial_data, rclk and clear SHALL each pass through a SYNC_STAGES-deep synchronizer; every edge is detected on the synchronized copy.
REQ-016 Each serial_clk falling edge SHALL shift the synchronized data in: shreg <= {shreg[30:0], data}.
REQ-017 rclk SHALL be sampled only at serial_clk falling edges; high now and low at the previous falling edge latches the post-shift shreg into word.
REQ-018 The latch SHALL occur in the same clk cycle as the shift; word_valid SHALL pulse exactly 1 clk later.
REQ-019 Field mapping: word[31-i] is the cathode bit of column i (active-low); word[15-j] is the anode bit of row j.
REQ-020 A word SHALL be valid only when word[31:16] contains exactly one 0, whose position gives column c; any other word is discarded (no word_valid, no accumulation).
REQ-021 For each valid word, acc[c][j] SHALL increment, saturating at 3, for every row j with anode bit 1; visit[c] (2-bit) increments.
REQ-022 When visit[c] wraps from 3 to 0, acc[c] SHALL be copied to fb[c] and cleared in that same cycle; frame_done pulses if c == 15.
REQ-023 rd_pix SHALL be fb[rd_col][rd_row], registered with 1-cycle read latency.
REQ-024 A simultaneous publish and read of the same pixel SHALL return the old value that cycle and the new value the next cycle.
REQ-025 clear low SHALL zero shreg only; it does not affect word, acc, visit or fb.
REQ-026 If clear is low at a shift edge, clear wins and shreg becomes 0.
REQ-027 Operation is guaranteed for serial_clk high and low phases of at least SYNC_STAGES+2 clk cycles each.

Reset
REQ-028 While rst_n is low at a clk edge, the block SHALL zero the synchronizers, shreg, word, acc, visit, fb and err_cnt, and drive rd_pix = 0, word_valid = 0 and frame_done = 0.
REQ-029 A reset mid-word SHALL discard partial bits; the first rclk after release latches whatever has shifted in since release.

Configuration
REQ-030 With MATRIX_RX_ERR_CNT_EN defined, port err_cnt SHALL exist and count discarded words, saturating at 255.
REQ-031 Without MATRIX_RX_ERR_CNT_EN, the port and counter SHALL be absent; discard behaviour is unchanged.

Structure
REQ-032 Package matrix_pkg SHALL hold MATRIX_DIM = 16, LINK_WORD_W = 32, SUBFRAMES = 4 and typedef pix_t (logic [1:0]); it is shared with the transmitter.
REQ-033 Sub-module sync_edge SHALL implement the synchronizer plus rise/fall pulse outputs; it is instantiated once per serial input.

Verification
REQ-034 Shift 32 bits of 0xFFFE8001 (column 15 selected, rows 0 and 15 on) with rclk asserted in the bit-32 cycle -> word_valid once; word = 0xFFFE8001; no publish yet.
REQ-035 Send the column-15 word with rows 0 and 15 on in 3 of 4 visits and off in the 4th -> frame_done pulses; rd_col = 15, rd_row = 0 and rd_row = 15 read 3; other rows of column 15 read 0.
REQ-036 Send a cathode field of 0xFFFC (two zeros) -> no word_valid; acc unchanged; err_cnt = 1 with macro defined.
REQ-037 Drive a full 64-word diagonal pattern (fb[k][k] = 3, fb[k][15-k] = 1) -> one frame_done; all 256 reads match the pattern.
REQ-038 Hold clear low for 4 serial_clk periods mid-word, then latch -> word = only the bits shifted in after clear release.
REQ-039 Assert rst_n low after 20 bits of a word -> all outputs 0; the next full word after release decodes correctly.
